// File: rtl/disp_frame_sched.sv
// disp_frame_sched: arbitrates timer/stopwatch/alarm frames onto a 74HC595
// display chain, serialising one 16-bit {seg, dig} word per digit.
module disp_frame_sched #(
  parameter int unsigned SCLK_DIV     = 4,
  parameter int unsigned DIGIT_HOLD   = 1000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        mode_timer,
  input  logic        mode_stopwatch,
  input  logic        mode_alarm,
  input  logic [31:0] data_timer,
  input  logic [31:0] data_stopwatch,
  input  logic [31:0] disp_alarm,
  input  logic [23:0] blink_mask,
  output logic        data_ser,
  output logic        srclk,
  output logic        rclk,
  output logic [1:0]  owner,
  output logic [2:0]  frame_ack,
  output logic        frame_done
);

  localparam int unsigned CNT_MAX = (SCLK_DIV > DIGIT_HOLD) ? SCLK_DIV : DIGIT_HOLD;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'((DIGIT_HOLD > 0) ? DIGIT_HOLD - 1 : 0);
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_LATCH, S_HOLD} state_e;

  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'hBF;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  function automatic logic [15:0] digit_word(input logic [31:0] data, input logic [7:0] mask,
                                             input logic phase, input logic [2:0] d);
    logic [7:0] seg;
    logic [7:0] dig;
    seg = (phase && mask[d]) ? 8'hFF : seg_decode(data[{d, 2'b00} +: 4]);
    dig = 8'b1 << d;
    return {seg, dig};
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          half_q, half_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   sh_q, sh_d;
  logic [2:0]    digit_q, digit_d;
  logic [31:0]   data_q, data_d;
  logic [7:0]    mask_q, mask_d;
  logic          fphase_q, fphase_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [1:0]    owner_q, owner_d;
  logic [2:0]    ack_q, ack_d;

  logic [1:0]    sel_owner;
  logic [31:0]   sel_data;
  logic [7:0]    sel_mask;
  logic [2:0]    sel_ack;
  logic          digit_end;
  logic          done_c;

  // Fixed-priority source selection; no source blanks every digit.
  always_comb begin
    sel_owner = 2'd0;
    sel_data  = '1;
    sel_mask  = '0;
    sel_ack   = '0;
    if (mode_alarm) begin
      sel_owner = 2'd3; sel_data = disp_alarm;     sel_mask = blink_mask[23:16]; sel_ack = 3'b100;
    end else if (mode_stopwatch) begin
      sel_owner = 2'd2; sel_data = data_stopwatch; sel_mask = blink_mask[15:8];  sel_ack = 3'b010;
    end else if (mode_timer) begin
      sel_owner = 2'd1; sel_data = data_timer;     sel_mask = blink_mask[7:0];   sel_ack = 3'b001;
    end
  end

  // Frame/digit sequencing, word serialisation and blink scheduling.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    digit_d     = digit_q;
    data_d      = data_q;
    mask_d      = mask_q;
    fphase_d    = fphase_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    owner_d     = owner_q;
    ack_d       = '0;
    digit_end   = 1'b0;
    done_c      = 1'b0;

    case (state_q)
      S_LOAD: begin
        owner_d  = sel_owner;
        data_d   = sel_data;
        mask_d   = sel_mask;
        fphase_d = blink_ph_q;
        ack_d    = sel_ack;
        digit_d  = '0;
        cnt_d    = '0;
        half_d   = 1'b0;
        bit_d    = '0;
        // First word is built straight from the inputs since the frame register loads on this edge.
        sh_d     = digit_word(sel_data, sel_mask, blink_ph_q, 3'd0);
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            sh_d   = {sh_q[14:0], 1'b0};
            bit_d  = bit_q + 4'd1;
            if (bit_q == 4'd15) state_d = S_LATCH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LATCH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (DIGIT_HOLD == 0) digit_end = 1'b1;
          else                 state_d   = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d     = '0;
          digit_end = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_LOAD;
    endcase

    if (digit_end) begin
      if (digit_q == 3'd7) begin
        state_d = S_LOAD;
        digit_d = '0;
        done_c  = 1'b1;
      end else begin
        state_d = S_SHIFT;
        digit_d = digit_q + 3'd1;
        half_d  = 1'b0;
        bit_d   = '0;
        sh_d    = digit_word(data_q, mask_q, fphase_q, digit_q + 3'd1);
      end
    end

    if (done_c) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      half_q      <= 1'b0;
      bit_q       <= '0;
      sh_q        <= '0;
      digit_q     <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      fphase_q    <= 1'b0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      owner_q     <= '0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      digit_q     <= digit_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      fphase_q    <= fphase_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      owner_q     <= owner_d;
      ack_q       <= ack_d;
    end
  end

  assign srclk      = (state_q == S_SHIFT) && half_q;
  assign data_ser   = (state_q == S_SHIFT) && sh_q[15];
  assign rclk       = (state_q == S_LATCH);
  assign owner      = owner_q;
  assign frame_ack  = ack_q;
  assign frame_done = done_c;

endmodule
